// File: rtl/rx_chan_collect.sv
// Collects per-channel 24-bit I/Q samples into a staging bank, transfers complete frames to a hold bank,
// and serves them as 16-bit words. Optional macro RX_COLLECT_TEST_EN replaces held data with a counter pattern.
module rx_chan_collect #(
  parameter  int NCHAN = 4,
  parameter  int DW    = 24,
  localparam int CW    = $clog2(NCHAN)
) (
  input  logic                adc_clk,
  input  logic                adc_rst_n,
  input  logic [NCHAN-1:0]    rx_en_A,
  input  logic [NCHAN-1:0]    rx_strobe_A,
  input  logic [NCHAN*DW-1:0] rx_i_A,
  input  logic [NCHAN*DW-1:0] rx_q_A,
  input  logic                ser,
  input  logic                rd_getI,
  input  logic                rd_getQ,
  input  logic                ovfl_clr_A,
  output logic                rx_avail_A,
  output logic [15:0]         rx_dout_A,
  output logic                busy_A,
  output logic [CW-1:0]       chan_A,
  output logic [NCHAN-1:0]    ovfl_A
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    stg_i  [NCHAN];
  logic [DW-1:0]    stg_q  [NCHAN];
  logic [DW-1:0]    hold_i [NCHAN];
  logic [DW-1:0]    hold_q [NCHAN];
  logic [NCHAN-1:0] pend;
  logic [NCHAN-1:0] en_lat;
  logic [NCHAN-1:0] ovfl_set;
  logic [1:0]       widx, widx_d;
  logic [CW-1:0]    chan_d, first_en, first_lat, next_chan;
  logic             next_found;
  logic             avail_d;
  logic             transfer;
  logic [15:0]      word_sel;

  assign transfer = (state_q == IDLE) && (rx_en_A != '0) && ((pend & rx_en_A) == rx_en_A);
  // A channel being transferred this edge has its pend cleared, so a coincident strobe is not an overrun.
  assign ovfl_set = rx_strobe_A & pend & ~({NCHAN{transfer}} & rx_en_A);
  assign busy_A   = (state_q == BUSY);

  // Lowest enabled channel (live mask and frame mask) and next higher channel of the current frame.
  always_comb begin
    first_en   = '0;
    first_lat  = '0;
    next_chan  = chan_A;
    next_found = 1'b0;
    for (int c = NCHAN - 1; c >= 0; c--) begin
      if (rx_en_A[c]) first_en = c[CW-1:0];
      if (en_lat[c])  first_lat = c[CW-1:0];
      if (en_lat[c] && (c > int'(chan_A))) begin
        next_chan  = c[CW-1:0];
        next_found = 1'b1;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_A;
    widx_d  = widx;
    avail_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          state_d = BUSY;
          chan_d  = first_en;
          widx_d  = 2'd0;
          avail_d = 1'b1;
        end
      end
      BUSY: begin
        if (ser) begin
          widx_d = 2'd0;
          if (next_found) begin
            chan_d = next_chan;
          end else begin
            state_d = IDLE;
            chan_d  = first_lat;
          end
        end else if (rd_getI || rd_getQ) begin
          widx_d = (widx == 2'd2) ? 2'd0 : widx + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (widx)
      2'd0:    word_sel = hold_i[chan_A][DW-1 -: 16];
      2'd1:    word_sel = hold_q[chan_A][DW-1 -: 16];
      default: word_sel = {hold_i[chan_A][7:0], hold_q[chan_A][7:0]};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state_q    <= IDLE;
      chan_A     <= '0;
      widx       <= '0;
      rx_avail_A <= 1'b0;
      rx_dout_A  <= '0;
      en_lat     <= '0;
      pend       <= '0;
      ovfl_A     <= '0;
    end else begin
      state_q    <= state_d;
      chan_A     <= chan_d;
      widx       <= widx_d;
      rx_avail_A <= avail_d;
      rx_dout_A  <= word_sel;
      if (transfer) en_lat <= rx_en_A;
      pend       <= rx_strobe_A | (pend & ~({NCHAN{transfer}} & rx_en_A));
      ovfl_A     <= ovfl_clr_A ? ovfl_set : (ovfl_A | ovfl_set);
    end
  end

`ifdef RX_COLLECT_TEST_EN
  logic [15:0] frame_ctr;
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n)    frame_ctr <= '0;
    else if (transfer) frame_ctr <= frame_ctr + 16'd1;
  end
`endif

  // NOTE: the sample banks are reset too, since the served data must read zero before the first frame.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      for (int c = 0; c < NCHAN; c++) begin
        stg_i[c]  <= '0;
        stg_q[c]  <= '0;
        hold_i[c] <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (rx_strobe_A[c]) begin
          stg_i[c] <= rx_i_A[c*DW +: DW];
          stg_q[c] <= rx_q_A[c*DW +: DW];
        end
        if (transfer && rx_en_A[c]) begin
`ifdef RX_COLLECT_TEST_EN
          hold_i[c] <= DW'({8'hA0 | 8'(c), frame_ctr});
          hold_q[c] <= DW'({8'hB0 | 8'(c), ~frame_ctr});
`else
          hold_i[c] <= stg_i[c];
          hold_q[c] <= stg_q[c];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_chan_collect.sv
// Self-checking bench for rx_chan_collect: directed vector table, hand sequences for corner cases,
// and randomized traffic checked against a frame-level reference model.
module tb_rx_chan_collect;

  localparam int NCHAN = 4;
  localparam int DW    = 24;

  logic              adc_clk = 1'b0;
  logic              adc_rst_n = 1'b0;
  logic [NCHAN-1:0]  rx_en_A = '0;
  logic [NCHAN-1:0]  rx_strobe_A = '0;
  logic [NCHAN*DW-1:0] rx_i_A = '0;
  logic [NCHAN*DW-1:0] rx_q_A = '0;
  logic              ser = 1'b0;
  logic              rd_getI = 1'b0;
  logic              rd_getQ = 1'b0;
  logic              ovfl_clr_A = 1'b0;
  logic              rx_avail_A;
  logic [15:0]       rx_dout_A;
  logic              busy_A;
  logic [1:0]        chan_A;
  logic [NCHAN-1:0]  ovfl_A;

  int n_total = 0;
  int n_pass  = 0;

  rx_chan_collect #(.NCHAN(NCHAN), .DW(DW)) dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .rx_en_A(rx_en_A), .rx_strobe_A(rx_strobe_A),
    .rx_i_A(rx_i_A), .rx_q_A(rx_q_A), .ser(ser), .rd_getI(rd_getI), .rd_getQ(rd_getQ),
    .ovfl_clr_A(ovfl_clr_A), .rx_avail_A(rx_avail_A), .rx_dout_A(rx_dout_A), .busy_A(busy_A),
    .chan_A(chan_A), .ovfl_A(ovfl_A)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic set_data(input int c, input logic [23:0] i, input logic [23:0] q);
    rx_i_A[c*DW +: DW] = i;
    rx_q_A[c*DW +: DW] = q;
  endtask

  // One clock: apply one-shot inputs, step past the edge, then drop them.
  task automatic cycle(input logic [3:0] stb, input logic s, input logic gi, input logic gq, input logic clr);
    rx_strobe_A = stb; ser = s; rd_getI = gi; rd_getQ = gq; ovfl_clr_A = clr;
    @(posedge adc_clk); #1;
    rx_strobe_A = '0; ser = 1'b0; rd_getI = 1'b0; rd_getQ = 1'b0; ovfl_clr_A = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    adc_rst_n = 1'b0;
    rx_strobe_A = '0; ser = 1'b0; rd_getI = 1'b0; rd_getQ = 1'b0; ovfl_clr_A = 1'b0;
    rx_i_A = '0; rx_q_A = '0;
    repeat (2) @(posedge adc_clk);
    #1;
    check({tag, "_rst_avail"}, 32'(rx_avail_A), 0);
    check({tag, "_rst_busy"},  32'(busy_A), 0);
    check({tag, "_rst_dout"},  32'(rx_dout_A), 0);
    check({tag, "_rst_chan"},  32'(chan_A), 0);
    check({tag, "_rst_ovfl"},  32'(ovfl_A), 0);
    adc_rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  en, stb;
    logic        s, gi, gq;
    logic [23:0] i0, q0, i1, q1;
    logic        x_avail, x_busy;
    logic [1:0]  x_chan;
    logic [15:0] x_dout;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] stb, input logic s, input logic gi, input logic gq,
                              input logic xa, input logic xb, input logic [1:0] xc, input logic [15:0] xd);
    vec_t v;
    v.en = 4'b0011; v.stb = stb; v.s = s; v.gi = gi; v.gq = gq;
    v.i0 = 24'h123456; v.q0 = 24'hABCDEF; v.i1 = 24'h654321; v.q1 = 24'h0FEDCB;
    v.x_avail = xa; v.x_busy = xb; v.x_chan = xc; v.x_dout = xd;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [23:0] m_si [NCHAN];
  logic [23:0] m_sq [NCHAN];
  logic [15:0] m_hw [NCHAN][3];
  logic [3:0]  m_pend, m_ovfl;
  bit          m_busy, m_avail;
  int          m_order[$];
  int          m_pos, m_chan, m_idx;
  logic [15:0] m_dout;
  logic [15:0] m_fc;

  task automatic model_reset();
    for (int c = 0; c < NCHAN; c++) begin
      m_si[c] = '0; m_sq[c] = '0;
      for (int w = 0; w < 3; w++) m_hw[c][w] = '0;
    end
    m_pend = '0; m_ovfl = '0; m_busy = 0; m_avail = 0;
    m_order.delete(); m_pos = 0; m_chan = 0; m_idx = 0; m_dout = '0; m_fc = '0;
  endtask

  task automatic model_step(input logic [3:0] en, input logic [3:0] stb, input logic s,
                            input logic gi, input logic gq, input logic clr);
    logic [15:0] d;
    logic [23:0] hi, hq;
    logic [3:0]  ov;
    bit          xfer;
    d    = m_hw[m_chan][m_idx];
    xfer = !m_busy && (en != 0) && ((m_pend & en) == en);
    m_avail = xfer;
    if (xfer) begin
      m_order.delete();
      for (int c = 0; c < NCHAN; c++) begin
        if (en[c]) begin
          m_order.push_back(c);
`ifdef RX_COLLECT_TEST_EN
          hi = {8'hA0 | 8'(c), m_fc};
          hq = {8'hB0 | 8'(c), ~m_fc};
`else
          hi = m_si[c];
          hq = m_sq[c];
`endif
          m_hw[c][0] = hi[23:8];
          m_hw[c][1] = hq[23:8];
          m_hw[c][2] = {hi[7:0], hq[7:0]};
          m_pend[c] = 1'b0;
        end
      end
      m_fc++;
      m_pos = 0; m_chan = m_order[0]; m_idx = 0; m_busy = 1;
    end else if (m_busy) begin
      if (s) begin
        m_pos++;
        if (m_pos >= m_order.size()) begin
          m_busy = 0;
          m_pos  = 0;
        end
        m_chan = m_order[m_pos];
        m_idx  = 0;
      end else if (gi || gq) begin
        m_idx = (m_idx + 1) % 3;
      end
    end
    ov = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (stb[c]) begin
        if (m_pend[c]) ov[c] = 1'b1;
        m_pend[c] = 1'b1;
        m_si[c] = rx_i_A[c*DW +: DW];
        m_sq[c] = rx_q_A[c*DW +: DW];
      end
    end
    m_ovfl = clr ? ov : (m_ovfl | ov);
    m_dout = d;
  endtask

  initial begin
    vec_t tbl[16];

    // ---- table: first frame, word order, channel advance, idle ignore ----
    do_reset("t1");
    tbl[0]  = mk(4'b0001, 0, 0, 0, 0, 0, 2'd0, 16'h0000);
    tbl[1]  = mk(4'b0000, 0, 0, 0, 0, 0, 2'd0, 16'h0000);
    tbl[2]  = mk(4'b0000, 0, 0, 0, 0, 0, 2'd0, 16'h0000);
    tbl[3]  = mk(4'b0010, 0, 0, 0, 0, 0, 2'd0, 16'h0000);
    tbl[4]  = mk(4'b0000, 0, 0, 0, 1, 1, 2'd0, 16'h0000);
    tbl[5]  = mk(4'b0000, 0, 0, 0, 0, 1, 2'd0, 16'h1234);
    tbl[6]  = mk(4'b0000, 0, 1, 0, 0, 1, 2'd0, 16'h1234);
    tbl[7]  = mk(4'b0000, 0, 0, 0, 0, 1, 2'd0, 16'hABCD);
    tbl[8]  = mk(4'b0000, 0, 1, 0, 0, 1, 2'd0, 16'hABCD);
    tbl[9]  = mk(4'b0000, 0, 0, 0, 0, 1, 2'd0, 16'h56EF);
    tbl[10] = mk(4'b0000, 1, 0, 0, 0, 1, 2'd1, 16'h56EF);
    tbl[11] = mk(4'b0000, 0, 0, 1, 0, 1, 2'd1, 16'h6543);
    tbl[12] = mk(4'b0000, 0, 0, 0, 0, 1, 2'd1, 16'h0FED);
    tbl[13] = mk(4'b0000, 1, 0, 0, 0, 0, 2'd0, 16'h0FED);
    tbl[14] = mk(4'b0000, 0, 0, 0, 0, 0, 2'd0, 16'h1234);
    tbl[15] = mk(4'b0000, 1, 1, 1, 0, 0, 2'd0, 16'h1234);
`ifndef RX_COLLECT_TEST_EN
    for (int r = 0; r < 16; r++) begin
      rx_en_A = tbl[r].en;
      set_data(0, tbl[r].i0, tbl[r].q0);
      set_data(1, tbl[r].i1, tbl[r].q1);
      cycle(tbl[r].stb, tbl[r].s, tbl[r].gi, tbl[r].gq, 1'b0);
      check($sformatf("tbl%0d_avail", r), 32'(rx_avail_A), 32'(tbl[r].x_avail));
      check($sformatf("tbl%0d_busy", r),  32'(busy_A),     32'(tbl[r].x_busy));
      check($sformatf("tbl%0d_chan", r),  32'(chan_A),     32'(tbl[r].x_chan));
      check($sformatf("tbl%0d_dout", r),  32'(rx_dout_A),  32'(tbl[r].x_dout));
    end
    check("tbl_ovfl", 32'(ovfl_A), 0);
`endif

    // ---- sparse enable mask 1010 ----
    do_reset("t3");
    rx_en_A = 4'b1010;
    set_data(1, 24'h111111, 24'h222222);
    set_data(3, 24'h333333, 24'h444444);
    cycle(4'b1010, 0, 0, 0, 0);
    check("t3_no_early_avail", 32'(rx_avail_A), 0);
    cycle(4'b0000, 0, 0, 0, 0);
    check("t3_avail", 32'(rx_avail_A), 1);
    check("t3_chan_first", 32'(chan_A), 1);
    cycle(4'b0000, 1, 0, 0, 0);
    check("t3_chan_next", 32'(chan_A), 3);
    cycle(4'b0000, 1, 0, 0, 0);
    check("t3_idle_busy", 32'(busy_A), 0);
    check("t3_idle_chan", 32'(chan_A), 1);

    // ---- overrun and clear ----
    do_reset("t4");
    rx_en_A = 4'b0011;
    set_data(0, 24'hAAAAAA, 24'hBBBBBB);
    cycle(4'b0001, 0, 0, 0, 0);
    set_data(0, 24'h777788, 24'h999999);
    cycle(4'b0001, 0, 0, 0, 0);
    check("t4_ovfl_set", 32'(ovfl_A), 4'b0001);
    set_data(1, 24'h010203, 24'h040506);
    cycle(4'b0010, 0, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0, 0);
    check("t4_avail", 32'(rx_avail_A), 1);
    cycle(4'b0000, 0, 0, 0, 0);
    check("t4_second_sample", 32'(rx_dout_A), 16'h7777);
    cycle(4'b0000, 0, 0, 0, 1);
    check("t4_clr", 32'(ovfl_A), 0);
    cycle(4'b0001, 0, 0, 0, 0);
    check("t4_no_ovfl_after_xfer", 32'(ovfl_A), 0);
    cycle(4'b0001, 0, 0, 0, 1);
    check("t4_set_beats_clr", 32'(ovfl_A), 4'b0001);

    // ---- strobe on the transfer edge, then async reset mid-frame ----
    do_reset("t5");
    rx_en_A = 4'b0011;
    set_data(0, 24'hC0FFEE, 24'h000000);
    cycle(4'b0001, 0, 0, 0, 0);
    cycle(4'b0010, 0, 0, 0, 0);
    set_data(0, 24'h5A5A5A, 24'h000000);
    cycle(4'b0001, 0, 0, 0, 0);
    check("t5_xfer_avail", 32'(rx_avail_A), 1);
    check("t5_xfer_no_ovfl", 32'(ovfl_A), 0);
    cycle(4'b0000, 0, 0, 0, 0);
    check("t5_old_sample", 32'(rx_dout_A), 16'hC0FF);
    cycle(4'b0000, 1, 0, 0, 0);
    cycle(4'b0000, 1, 0, 0, 0);
    check("t5_idle", 32'(busy_A), 0);
    cycle(4'b0010, 0, 0, 0, 0);
    check("t5_no_early", 32'(rx_avail_A), 0);
    cycle(4'b0000, 0, 0, 0, 0);
    check("t5_second_avail", 32'(rx_avail_A), 1);
    cycle(4'b0000, 0, 0, 0, 0);
    check("t5_new_sample", 32'(rx_dout_A), 16'h5A5A);
    cycle(4'b0000, 1, 0, 0, 0);
    check("t5_chan1", 32'(chan_A), 1);
    #2 adc_rst_n = 1'b0;
    #1;
    check("t5_async_busy", 32'(busy_A), 0);
    check("t5_async_chan", 32'(chan_A), 0);
    check("t5_async_dout", 32'(rx_dout_A), 0);
    check("t5_async_avail", 32'(rx_avail_A), 0);

`ifdef RX_COLLECT_TEST_EN
    // ---- test pattern frames, including counter wrap ----
    do_reset("t6");
    rx_en_A = 4'b0011;
    for (int f = 0; f < 4; f++) begin
      if (f == 3) begin
        force dut.frame_ctr = 16'hFFFF;
        #1 release dut.frame_ctr;
      end
      cycle(4'b0011, 0, 0, 0, 0);
      cycle(4'b0000, 0, 0, 0, 0);
      cycle(4'b0000, 1, 0, 0, 0);
      cycle(4'b0000, 0, 0, 0, 0);
      check($sformatf("t6_f%0d_w0", f), 32'(rx_dout_A), (f == 3) ? 16'hA1FF : 16'hA100);
      cycle(4'b0000, 0, 1, 0, 0);
      cycle(4'b0000, 0, 1, 0, 0);
      cycle(4'b0000, 0, 0, 0, 0);
      check($sformatf("t6_f%0d_w2", f), 32'(rx_dout_A),
            (f == 3) ? 16'hFF00 : {8'(f), ~8'(f)});
      cycle(4'b0000, 1, 0, 0, 0);
    end
    cycle(4'b0011, 0, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0, 0);
    check("t6_wrap_w0", 32'(rx_dout_A), 16'hA000);
    cycle(4'b0000, 0, 1, 0, 0);
    cycle(4'b0000, 0, 1, 0, 0);
    cycle(4'b0000, 0, 0, 0, 0);
    check("t6_wrap_w2", 32'(rx_dout_A), 16'h00FF);
`endif

    // ---- randomized traffic against the reference model ----
    do_reset("rnd");
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] stb;
      logic s, gi, gq, clr;
      if (n % 64 == 0) rx_en_A = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      rx_i_A = {$urandom, $urandom, $urandom};
      rx_q_A = {$urandom, $urandom, $urandom};
      for (int c = 0; c < NCHAN; c++) stb[c] = ($urandom_range(0, 5) == 0);
      s   = ($urandom_range(0, 7) == 0);
      gi  = ($urandom_range(0, 3) == 0);
      gq  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 19) == 0);
      model_step(rx_en_A, stb, s, gi, gq, clr);
      cycle(stb, s, gi, gq, clr);
      check("rnd_avail", 32'(rx_avail_A), 32'(m_avail));
      check("rnd_busy",  32'(busy_A),     32'(m_busy));
      check("rnd_chan",  32'(chan_A),     32'(m_chan));
      check("rnd_dout",  32'(rx_dout_A),  32'(m_dout));
      check("rnd_ovfl",  32'(ovfl_A),     32'(m_ovfl));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
